writeback_stage: RTL

//   MEM/WB pipeline register and write-back logic of the 16-bit 4-register CPU.

---
 rtl/writeback_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back logic.
// Drives the register-file write port, EX bypass, retire counter, WWD port and halt.
module writeback_stage #(
   parameter int WORD_SIZE  = 16,
   parameter int REG_ADDR_W = 2,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_valid,
   input  logic                  i_reg_write,
   input  logic [REG_ADDR_W-1:0] i_dest,
   input  logic [1:0]            i_wb_sel,
   input  logic [WORD_SIZE-1:0]  i_alu_result,
   input  logic [WORD_SIZE-1:0]  i_mem_data,
   input  logic [WORD_SIZE-1:0]  i_pc_plus1,
   input  logic                  i_is_wwd,
   input  logic [WORD_SIZE-1:0]  i_wwd_data,
   input  logic                  i_is_halt,
   output logic                  rf_write_en,
   output logic [REG_ADDR_W-1:0] rf_write_reg,
   output logic [WORD_SIZE-1:0]  rf_write_data,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_reg,
   output logic [WORD_SIZE-1:0]  fwd_data,
   output logic [CNT_W-1:0]      num_inst,
   output logic [WORD_SIZE-1:0]  output_port,
   output logic                  is_halted
);

   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_PC  = 2'b10;

   logic                  v_q, v_d;
   logic                  rw_q, rw_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   logic [1:0]            sel_q, sel_d;
   logic [WORD_SIZE-1:0]  alu_q, alu_d;
   logic [WORD_SIZE-1:0]  mem_q, mem_d;
   logic [WORD_SIZE-1:0]  pc_q, pc_d;
   logic                  wwd_q, wwd_d;
   logic [WORD_SIZE-1:0]  wwd_data_q, wwd_data_d;
   logic                  halt_q, halt_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WORD_SIZE-1:0]  port_q, port_d;
   logic                  halted_q, halted_d;
   logic                  retire;
   logic [WORD_SIZE-1:0]  wb_data;

   assign retire = v_q & ~halted_q;

   always_comb begin
      v_d        = i_valid & ~halted_q;
      rw_d       = i_reg_write;
      dest_d     = i_dest;
      sel_d      = i_wb_sel;
      alu_d      = i_alu_result;
      mem_d      = i_mem_data;
      pc_d       = i_pc_plus1;
      wwd_d      = i_is_wwd;
      wwd_data_d = i_wwd_data;
      halt_d     = i_is_halt;
      cnt_d      = cnt_q;
      port_d     = port_q;
      halted_d   = halted_q;
      if (retire) begin
         cnt_d = cnt_q + 1'b1;
         if (wwd_q)  port_d   = wwd_data_q;
         if (halt_q) halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v_q        <= 1'b0;
         rw_q       <= 1'b0;
         dest_q     <= '0;
         sel_q      <= SEL_ALU;
         alu_q      <= '0;
         mem_q      <= '0;
         pc_q       <= '0;
         wwd_q      <= 1'b0;
         wwd_data_q <= '0;
         halt_q     <= 1'b0;
         cnt_q      <= '0;
         port_q     <= '0;
         halted_q   <= 1'b0;
      end else begin
         v_q        <= v_d;
         rw_q       <= rw_d;
         dest_q     <= dest_d;
         sel_q      <= sel_d;
         alu_q      <= alu_d;
         mem_q      <= mem_d;
         pc_q       <= pc_d;
         wwd_q      <= wwd_d;
         wwd_data_q <= wwd_data_d;
         halt_q     <= halt_d;
         cnt_q      <= cnt_d;
         port_q     <= port_d;
         halted_q   <= halted_d;
      end
   end

   // Select 11 is reserved: it yields zero and suppresses the write.
   always_comb begin
      unique case (sel_q)
         SEL_ALU: wb_data = alu_q;
         SEL_MEM: wb_data = mem_q;
         SEL_PC:  wb_data = pc_q;
         default: wb_data = '0;
      endcase
   end

   assign rf_write_en   = retire & rw_q & (sel_q != 2'b11);
   assign rf_write_reg  = dest_q;
   assign rf_write_data = wb_data;
   assign fwd_valid     = rf_write_en;
   assign fwd_reg       = dest_q;
   assign fwd_data      = wb_data;
   assign num_inst      = cnt_q;
   assign output_port   = port_q;
   assign is_halted     = halted_q;

endmodule
